// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared constants and types for the Hack CPU memory responder.
// Holds the I/O page addresses, status register bit positions and the
// address-region decode used by hack_mem_responder.
package hack_mem_pkg;

    // Memory-mapped I/O page addresses
    localparam logic [13:0] KBD_DATA_ADDR = 14'h3FF0;
    localparam logic [13:0] KBD_STAT_ADDR = 14'h3FF1;
    localparam logic [13:0] TX_DATA_ADDR  = 14'h3FF8;
    localparam logic [13:0] TX_STAT_ADDR  = 14'h3FF9;

    // Status register bit positions
    localparam int unsigned KBD_STAT_FULL_BIT = 32'd0;
    localparam int unsigned TX_STAT_FULL_BIT  = 32'd0;
    localparam int unsigned TX_STAT_EMPTY_BIT = 32'd1;
    localparam int unsigned TX_STAT_CNT_LSB   = 32'd4;
    localparam int unsigned TX_STAT_CNT_MSB   = 32'd7;
    localparam int unsigned TX_STAT_OVF_BIT   = 32'd15;

    // Which target an address selects
    typedef enum logic [2:0] {
        REGION_RAM      = 3'd0,
        REGION_KBD_DATA = 3'd1,
        REGION_KBD_STAT = 3'd2,
        REGION_TX_DATA  = 3'd3,
        REGION_TX_STAT  = 3'd4,
        REGION_UNMAPPED = 3'd5
    } region_e;

    // Classify a CPU word address; RAM occupies 0..ram_depth-1.
    function automatic region_e decode_region(input logic [13:0] addr,
                                              input int unsigned ram_depth);
        region_e region_v;
        if (32'(addr) < ram_depth) begin
            region_v = REGION_RAM;
        end else begin
            case (addr)
                KBD_DATA_ADDR: region_v = REGION_KBD_DATA;
                KBD_STAT_ADDR: region_v = REGION_KBD_STAT;
                TX_DATA_ADDR:  region_v = REGION_TX_DATA;
                TX_STAT_ADDR:  region_v = REGION_TX_STAT;
                default:       region_v = REGION_UNMAPPED;
            endcase
        end
        return region_v;
    endfunction

endpackage

// File: rtl/hack_sync_fifo.sv
// hack_sync_fifo: single-clock FIFO with registered pointers and occupancy.
// Push while full and pop while empty are ignored. head_data shows the
// oldest entry and reads zero when the FIFO is empty. srst flushes the
// FIFO synchronously.
module hack_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head_data
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Occupancy flags and qualified push/pop
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        empty_s   = (count_r == {CNT_W{1'b0}});
        do_push_s = push && !full_s;
        do_pop_s  = pop && !empty_s;
    end

    // Storage write; contents need no reset because empty gates the head
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (srst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head word, forced to zero while empty
    always_comb begin
        if (empty_s) begin
            head_data = {WIDTH{1'b0}};
        end else begin
            head_data = mem_r[rd_ptr_r];
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/hack_mem_responder.sv
// hack_mem_responder: memory-side responder for the Hack CPU data port.
// Serves data RAM plus an I/O page holding a keyboard holding register and
// a display TX FIFO. Reads are unconditional with one cycle latency and
// read-first behaviour on a same-address write.
// Build option: define HACK_MEM_BOUNDS_CHECK_EN to make any access to an
// unmapped address raise the sticky bus_err flag; otherwise bus_err is 0.
module hack_mem_responder
    import hack_mem_pkg::*;
#(
    parameter int unsigned RAM_DEPTH     = 16368,
    parameter int unsigned TX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] addressM,
    input  logic        writeM,
    input  logic [15:0] outM,
    output logic [15:0] inM,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_data,
    output logic        kbd_ready,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int unsigned CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

    region_e          region_s;
    logic [15:0]      ram_r [RAM_DEPTH];
    logic [15:0]      ram_rd_s;
    logic [15:0]      rd_data_s;
    logic [15:0]      inm_r;
    logic             ram_we_s;

    logic             kbd_full_r;
    logic [15:0]      kbd_data_r;
    logic             kbd_accept_s;
    logic             kbd_clr_s;

    logic             tx_push_s;
    logic             tx_ovf_clr_s;
    logic             tx_ovf_r;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [15:0]      fifo_head_s;
    logic [31:0]      fifo_count_ext_s;
    logic [3:0]       tx_count_sat_s;
    logic [15:0]      tx_stat_s;

    // Address decode and per-target write strobes
    always_comb begin
        region_s     = decode_region(addressM, RAM_DEPTH);
        ram_we_s     = writeM && (region_s == REGION_RAM);
        kbd_clr_s    = writeM && (region_s == REGION_KBD_STAT);
        tx_push_s    = writeM && (region_s == REGION_TX_DATA);
        tx_ovf_clr_s = writeM && (region_s == REGION_TX_STAT);
        kbd_accept_s = kbd_valid && !kbd_full_r;
    end

    // Data RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[addressM] <= outM;
        end
    end

    assign ram_rd_s = ram_r[addressM];

    // Keyboard holding register; an accept always beats a status-clear write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kbd_full_r <= 1'b0;
            kbd_data_r <= 16'h0000;
        end else if (kbd_accept_s) begin
            kbd_full_r <= 1'b1;
            kbd_data_r <= kbd_data;
        end else if (kbd_clr_s) begin
            kbd_full_r <= 1'b0;
        end else begin
            kbd_full_r <= kbd_full_r;
        end
    end

    hack_sync_fifo #(
        .WIDTH (16),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .srst      (1'b0),
        .push      (tx_push_s),
        .push_data (outM),
        .pop       (tx_ready),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head_data (fifo_head_s)
    );

    // Sticky TX overflow: a push against a full FIFO (pre-edge view) is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf_r <= 1'b0;
        end else if (tx_ovf_clr_s) begin
            tx_ovf_r <= 1'b0;
        end else if (tx_push_s && fifo_full_s) begin
            tx_ovf_r <= 1'b1;
        end else begin
            tx_ovf_r <= tx_ovf_r;
        end
    end

    // TX status word with the count saturated to four bits
    always_comb begin
        fifo_count_ext_s = 32'(fifo_count_s);
        if (fifo_count_ext_s > 32'd15) begin
            tx_count_sat_s = 4'hF;
        end else begin
            tx_count_sat_s = fifo_count_ext_s[3:0];
        end
        tx_stat_s = 16'h0000;
        tx_stat_s[TX_STAT_FULL_BIT]                 = fifo_full_s;
        tx_stat_s[TX_STAT_EMPTY_BIT]                = fifo_empty_s;
        tx_stat_s[TX_STAT_CNT_MSB:TX_STAT_CNT_LSB]  = tx_count_sat_s;
        tx_stat_s[TX_STAT_OVF_BIT]                  = tx_ovf_r;
    end

    // Read mux; write-only and unmapped addresses read as zero
    always_comb begin
        rd_data_s = 16'h0000;
        case (region_s)
            REGION_RAM:      rd_data_s = ram_rd_s;
            REGION_KBD_DATA: rd_data_s = kbd_data_r;
            REGION_KBD_STAT: rd_data_s = {15'h0000, kbd_full_r};
            REGION_TX_STAT:  rd_data_s = tx_stat_s;
            default:         rd_data_s = 16'h0000;
        endcase
    end

    // Registered read data; sampling pre-edge state gives read-first behaviour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inm_r <= 16'h0000;
        end else begin
            inm_r <= rd_data_s;
        end
    end

`ifdef HACK_MEM_BOUNDS_CHECK_EN
    logic bus_err_r;

    // Sticky flag for any cycle presenting an unmapped address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_err_r <= 1'b0;
        end else if (region_s == REGION_UNMAPPED) begin
            bus_err_r <= 1'b1;
        end else begin
            bus_err_r <= bus_err_r;
        end
    end

    assign bus_err = bus_err_r;
`else
    assign bus_err = 1'b0;
`endif

    assign inM       = inm_r;
    assign kbd_ready = ~kbd_full_r;
    assign tx_valid  = ~fifo_empty_s;
    assign tx_data   = fifo_head_s;

endmodule

// File: tb/tb_hack_mem_responder.sv
// tb_hack_mem_responder: directed self-checking bench for hack_mem_responder
// (default parameters: RAM_DEPTH=16368, TX_FIFO_DEPTH=8).
module tb_hack_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [13:0] addressM = 14'h0000;
    logic        writeM = 1'b0;
    logic [15:0] outM = 16'h0000;
    logic [15:0] inM;
    logic        kbd_valid = 1'b0;
    logic [15:0] kbd_data = 16'h0000;
    logic        kbd_ready;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready = 1'b0;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

`ifdef HACK_MEM_BOUNDS_CHECK_EN
    localparam logic EXP_BUS_ERR = 1'b1;
`else
    localparam logic EXP_BUS_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    hack_mem_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addressM  (addressM),
        .writeM    (writeM),
        .outM      (outM),
        .inM       (inM),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .kbd_ready (kbd_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .bus_err   (bus_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        #10;
        checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL reset_inM: got %h expected %h", inM, 16'h0000); end
        checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL reset_kbd_ready: got %b expected 1", kbd_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL reset_tx_data: got %h expected 0000", tx_data); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_ram;
        addressM = 14'h0010; writeM = 1'b1; outM = 16'h1234; tick();
        writeM = 1'b0; tick();
        checks++; if (inM !== 16'h1234) begin errors++; $display("FAIL ram_rd_0010: got %h expected 1234", inM); end
        addressM = 14'h3FEF; writeM = 1'b1; outM = 16'hBEEF; tick();
        writeM = 1'b0; tick();
        checks++; if (inM !== 16'hBEEF) begin errors++; $display("FAIL ram_rd_last: got %h expected beef", inM); end
        addressM = 14'h0010; #1;
        checks++; if (inM !== 16'hBEEF) begin errors++; $display("FAIL ram_latency_hold: got %h expected beef", inM); end
        tick();
        checks++; if (inM !== 16'h1234) begin errors++; $display("FAIL ram_latency_next: got %h expected 1234", inM); end
    endtask

    task automatic test_read_first;
        addressM = 14'h0005; writeM = 1'b1; outM = 16'h0001; tick();
        outM = 16'h00FF; tick();
        checks++; if (inM !== 16'h0001) begin errors++; $display("FAIL read_first_old: got %h expected 0001", inM); end
        writeM = 1'b0; tick();
        checks++; if (inM !== 16'h00FF) begin errors++; $display("FAIL read_first_new: got %h expected 00ff", inM); end
    endtask

    task automatic test_keyboard;
        addressM = 14'h0000; kbd_valid = 1'b1; kbd_data = 16'h0041; #1;
        checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL kbd_ready_idle: got %b expected 1", kbd_ready); end
        tick();
        checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL kbd_ready_full: got %b expected 0", kbd_ready); end
        kbd_data = 16'h0042; addressM = 14'h3FF0; tick();
        checks++; if (inM !== 16'h0041) begin errors++; $display("FAIL kbd_data_first: got %h expected 0041", inM); end
        addressM = 14'h3FF1; tick();
        checks++; if (inM !== 16'h0001) begin errors++; $display("FAIL kbd_stat_full: got %h expected 0001", inM); end
        writeM = 1'b1; tick();
        checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL kbd_ready_after_clr: got %b expected 1", kbd_ready); end
        writeM = 1'b0; addressM = 14'h3FF0; tick();
        checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL kbd_ready_second: got %b expected 0", kbd_ready); end
        checks++; if (inM !== 16'h0041) begin errors++; $display("FAIL kbd_data_preaccept: got %h expected 0041", inM); end
        kbd_valid = 1'b0; tick();
        checks++; if (inM !== 16'h0042) begin errors++; $display("FAIL kbd_data_second: got %h expected 0042", inM); end
        addressM = 14'h3FF1; writeM = 1'b1; tick();
        writeM = 1'b0; tick();
        checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL kbd_stat_cleared: got %h expected 0000", inM); end
    endtask

    task automatic test_tx_fifo;
        tx_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            addressM = 14'h3FF8; writeM = 1'b1; outM = 16'h0100 + 16'(k); tick();
            if (k == 1) begin
                checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_first: got %b expected 1", tx_valid); end
                checks++; if (tx_data !== 16'h0101) begin errors++; $display("FAIL tx_data_first: got %h expected 0101", tx_data); end
            end
        end
        writeM = 1'b0; addressM = 14'h3FF9; tick();
        checks++; if (inM !== 16'h8081) begin errors++; $display("FAIL tx_stat_full_ovf: got %h expected 8081", inM); end
        tx_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_drain_valid_%0d: got %b expected 1", k, tx_valid); end
            checks++; if (tx_data !== 16'h0100 + 16'(k)) begin errors++; $display("FAIL tx_drain_data_%0d: got %h expected %h", k, tx_data, 16'h0100 + 16'(k)); end
            tick();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL tx_drained_data: got %h expected 0000", tx_data); end
        tx_ready = 1'b0; tick();
        checks++; if (inM !== 16'h8002) begin errors++; $display("FAIL tx_stat_empty_ovf: got %h expected 8002", inM); end
        writeM = 1'b1; tick();
        writeM = 1'b0; tick();
        checks++; if (inM !== 16'h0002) begin errors++; $display("FAIL tx_stat_ovf_cleared: got %h expected 0002", inM); end
    endtask

    task automatic test_back_to_back;
        tx_ready = 1'b1; addressM = 14'h3FF8; writeM = 1'b1; outM = 16'h0AAA; #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty_pre: got %b expected 0", tx_valid); end
        tick();
        writeM = 1'b0;
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_empty_valid: got %b expected 1", tx_valid); end
        checks++; if (tx_data !== 16'h0AAA) begin errors++; $display("FAIL b2b_empty_data: got %h expected 0aaa", tx_data); end
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_popped: got %b expected 0", tx_valid); end
        tx_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            writeM = 1'b1; outM = 16'h0200 + 16'(k); tick();
        end
        tx_ready = 1'b1; outM = 16'h0999; tick();
        tx_ready = 1'b0; writeM = 1'b0; addressM = 14'h3FF9; tick();
        checks++; if (inM !== 16'h8070) begin errors++; $display("FAIL b2b_full_stat: got %h expected 8070", inM); end
        tx_ready = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            checks++; if (tx_data !== 16'h0200 + 16'(k)) begin errors++; $display("FAIL b2b_full_data_%0d: got %h expected %h", k, tx_data, 16'h0200 + 16'(k)); end
            tick();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_full_drained: got %b expected 0", tx_valid); end
        tx_ready = 1'b0; writeM = 1'b1; tick();
        writeM = 1'b0; tick();
        checks++; if (inM !== 16'h0002) begin errors++; $display("FAIL b2b_ovf_cleared: got %h expected 0002", inM); end
    endtask

    task automatic test_unmapped;
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL unmapped_pre: got %b expected 0", bus_err); end
        addressM = 14'h3FF4; writeM = 1'b1; outM = 16'hFFFF; tick();
        writeM = 1'b0; tick();
        checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h expected 0000", inM); end
        checks++; if (bus_err !== EXP_BUS_ERR) begin errors++; $display("FAIL unmapped_bus_err: got %b expected %b", bus_err, EXP_BUS_ERR); end
        addressM = 14'h0010; tick(); tick();
        checks++; if (bus_err !== EXP_BUS_ERR) begin errors++; $display("FAIL unmapped_bus_err_held: got %b expected %b", bus_err, EXP_BUS_ERR); end
        checks++; if (inM !== 16'h1234) begin errors++; $display("FAIL unmapped_ram_intact: got %h expected 1234", inM); end
    endtask

    task automatic test_reset_mid;
        tx_ready = 1'b0; kbd_valid = 1'b1; kbd_data = 16'h0077; addressM = 14'h3FF8;
        for (int k = 1; k <= 3; k++) begin
            writeM = 1'b1; outM = 16'h0300 + 16'(k); tick();
        end
        kbd_valid = 1'b0; writeM = 1'b0; addressM = 14'h0010; tick();
        checks++; if (inM !== 16'h1234) begin errors++; $display("FAIL mid_pre_inM: got %h expected 1234", inM); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_tx_valid: got %b expected 1", tx_valid); end
        checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_kbd_ready: got %b expected 0", kbd_ready); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_tx_data: got %h expected 0000", tx_data); end
        checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL mid_rst_inM: got %h expected 0000", inM); end
        checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_kbd_ready: got %b expected 1", kbd_ready); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL mid_rst_bus_err: got %b expected 0", bus_err); end
        @(negedge clk);
        reset_n = 1'b1; addressM = 14'h3FF9;
        tick();
        checks++; if (inM !== 16'h0002) begin errors++; $display("FAIL mid_post_tx_stat: got %h expected 0002", inM); end
        addressM = 14'h3FF1; tick();
        checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL mid_post_kbd_stat: got %h expected 0000", inM); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_post_tx_valid: got %b expected 0", tx_valid); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_read_first();
        test_keyboard();
        test_tx_fifo();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
